afifo_xgmii_tx_ctrl: RTL and testbench

Read-side sequencer for the 72-bit XGMII frame FIFO (11-bit address), in the rd_clk domain.
- Pops complete frames from the FIFO and drives a registered 64-bit XGMII transmit stream.
- Enforces a minimum inter-packet gap and discards stray non-start words.
- On FIFO underrun mid-frame, emits an error word and flushes the rest of the frame.

---
 rtl/afifo_xgmii_tx_ctrl.sv | 149 ++++++++++++++
 tb/tb_afifo_xgmii_tx_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_xgmii_tx_ctrl.sv
// Read-side XGMII frame sequencer: pops whole frames from a show-ahead FIFO and enforces the IPG.
// Define AFIFO_TX_STATS_EN to implement frame/underrun/drop counters (otherwise tied to 0).
`timescale 1ns/1ps
module afifo_xgmii_tx_ctrl #(
    parameter int unsigned IPG_WORDS = 1
) (
    input  logic        rd_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [71:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [31:0] frame_cnt,
    output logic [15:0] underrun_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [63:0] IdleTxd = 64'h0707070707070707;
    localparam logic [63:0] ErrTxd  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [15:0] IpgLoad = 16'(IPG_WORDS);
    localparam logic        NoGap   = (IPG_WORDS == 0);

    typedef enum logic [1:0] {StIdle, StFrame, StAbort, StIpg} state_e;

    state_e      state_q, state_d;
    logic [15:0] ipg_q, ipg_d;
    logic [71:0] out_q, out_d;
    logic        pop;
    logic        is_start, is_term;
    logic        frame_inc, underrun_inc, drop_inc;

    assign is_start = fifo_dout[64] && (fifo_dout[7:0] == 8'hFB);

    always_comb begin
        is_term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_dout[64+i] && (fifo_dout[8*i +: 8] == 8'hFD)) begin
                is_term = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ipg_d        = ipg_q;
        pop          = 1'b0;
        out_d        = {8'hFF, IdleTxd};
        frame_inc    = 1'b0;
        underrun_inc = 1'b0;
        drop_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    pop = 1'b1;
                    if (is_start) begin
                        out_d = fifo_dout;
                        if (is_term) begin
                            frame_inc = 1'b1;
                            state_d   = NoGap ? StIdle : StIpg;
                            ipg_d     = IpgLoad;
                        end else begin
                            state_d = StFrame;
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            StFrame: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    out_d = fifo_dout;
                    if (is_term) begin
                        frame_inc = 1'b1;
                        state_d   = NoGap ? StIdle : StIpg;
                        ipg_d     = IpgLoad;
                    end
                end else begin
                    out_d        = {8'hFF, ErrTxd};
                    underrun_inc = 1'b1;
                    state_d      = StAbort;
                end
            end
            StAbort: begin
                // Flush the remainder of the broken frame, whatever it contains.
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_term) begin
                        state_d = NoGap ? StIdle : StIpg;
                        ipg_d   = IpgLoad;
                    end
                end
            end
            StIpg: begin
                ipg_d = ipg_q - 16'd1;
                if (ipg_q == 16'd1) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    assign fifo_rd_en = pop & ~rst;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ipg_q   <= 16'd0;
            out_q   <= {8'hFF, IdleTxd};
        end else begin
            state_q <= state_d;
            ipg_q   <= ipg_d;
            out_q   <= out_d;
        end
    end

    assign xgmii_txd = out_q[63:0];
    assign xgmii_txc = out_q[71:64];

`ifdef AFIFO_TX_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] underrun_cnt_q, drop_cnt_q;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q    <= 32'd0;
            underrun_cnt_q <= 16'd0;
            drop_cnt_q     <= 16'd0;
        end else begin
            frame_cnt_q    <= frame_cnt_q + 32'(frame_inc);
            underrun_cnt_q <= underrun_cnt_q + 16'(underrun_inc);
            drop_cnt_q     <= drop_cnt_q + 16'(drop_inc);
        end
    end

    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
    assign drop_cnt     = drop_cnt_q;
`else
    logic unused_inc;
    assign unused_inc   = frame_inc ^ underrun_inc ^ drop_inc;
    assign frame_cnt    = 32'd0;
    assign underrun_cnt = 16'd0;
    assign drop_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_afifo_xgmii_tx_ctrl.sv
// Self-checking bench for afifo_xgmii_tx_ctrl: queue-based FIFO, frame-level reference model.
`timescale 1ns/1ps
module tb_afifo_xgmii_tx_ctrl;

    localparam int unsigned TB_IPG = 3;
    localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
`ifdef AFIFO_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        rd_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [71:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [31:0] frame_cnt;
    logic [15:0] underrun_cnt;
    logic [15:0] drop_cnt;

    afifo_xgmii_tx_ctrl #(.IPG_WORDS(TB_IPG)) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int tests = 0;
    int fails = 0;

    // FIFO contents, words not yet written, output log, last built frame
    logic [71:0] fifo_q[$];
    logic [71:0] pending[$];
    logic [71:0] out_log[$];
    logic [71:0] frame_w[$];
    int          wr_pct = 100;
    bit          en_drv = 1'b1;
    int          pops = 0;

    // Reference model: frame-level flags plus cycle of the last terminate pop
    int          cyc = 0;
    int          last_term = -1000;
    bit          in_frame = 1'b0;
    bit          aborting = 1'b0;
    int          m_frames = 0, m_underruns = 0, m_drops = 0;
    logic [71:0] exp_out = IDLE_W;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ec(input int v);
        return STATS ? v : 0;
    endfunction

    function automatic bit w_is_start(input logic [71:0] w);
        return w[64] && (w[7:0] == 8'hFB);
    endfunction

    function automatic bit w_is_term(input logic [71:0] w);
        for (int i = 0; i < 8; i++) if (w[64+i] && (w[8*i +: 8] == 8'hFD)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [71:0] rnd_word(input logic [7:0] txc);
        return {txc, $urandom, $urandom};
    endfunction

    // Builds frame_w: START, data words, terminate in lane tl (tl<0: random lane).
    task automatic build_frame(input int n, input int tl);
        logic [71:0] w;
        int          l;
        frame_w.delete();
        for (int k = 0; k < n; k++) begin
            w = rnd_word(8'h00);
            if (k == n - 1) begin
                l = (tl >= 0) ? tl : ((n == 1) ? $urandom_range(7, 1) : $urandom_range(7, 0));
                w[71:64] = 8'hFF << l;
                w[8*l +: 8] = 8'hFD;
                for (int b = l + 1; b < 8; b++) w[8*b +: 8] = 8'h07;
            end
            if (k == 0) begin
                w[64]  = 1'b1;
                w[7:0] = 8'hFB;
            end
            frame_w.push_back(w);
        end
    endtask

    task automatic model_reset();
        in_frame = 1'b0; aborting = 1'b0; last_term = -1000;
        m_frames = 0; m_underruns = 0; m_drops = 0; exp_out = IDLE_W;
    endtask

    // One clock cycle: drive at negedge, compare, advance model and FIFO at posedge.
    task automatic step();
        logic [71:0] head, nxt;
        bit          empty, exp_pop, dut_pop;
        empty = (fifo_q.size() == 0);
        head  = empty ? rnd_word(8'($urandom)) : fifo_q[0];
        fifo_empty = empty;
        fifo_dout  = head;
        enable     = en_drv;
        #1;
        chk("xgmii_out", {xgmii_txc, xgmii_txd}, exp_out);
        chk("frame_cnt", 72'(frame_cnt), 72'(ec(m_frames)));
        chk("underrun_cnt", 72'(underrun_cnt), 72'(16'(ec(m_underruns))));
        chk("drop_cnt", 72'(drop_cnt), 72'(16'(ec(m_drops))));
        out_log.push_back({xgmii_txc, xgmii_txd});
        exp_pop = 1'b0;
        nxt     = IDLE_W;
        if (aborting) begin
            if (!empty) begin
                exp_pop = 1'b1;
                if (w_is_term(head)) begin aborting = 1'b0; last_term = cyc; end
            end
        end else if (in_frame) begin
            if (!empty) begin
                exp_pop = 1'b1;
                nxt = head;
                if (w_is_term(head)) begin in_frame = 1'b0; m_frames++; last_term = cyc; end
            end else begin
                nxt = ERR_W; m_underruns++; in_frame = 1'b0; aborting = 1'b1;
            end
        end else if (cyc >= last_term + int'(TB_IPG) + 1 && en_drv && !empty) begin
            exp_pop = 1'b1;
            if (w_is_start(head)) begin
                nxt = head;
                if (w_is_term(head)) begin m_frames++; last_term = cyc; end
                else in_frame = 1'b1;
            end else begin
                m_drops++;
            end
        end
        chk("fifo_rd_en", 72'(fifo_rd_en), 72'(exp_pop));
        dut_pop = fifo_rd_en;
        @(posedge rd_clk);
        if (dut_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        exp_out = nxt;
        cyc++;
        @(negedge rd_clk);
        if (pending.size() > 0 && $urandom_range(99, 0) < wr_pct) fifo_q.push_back(pending.pop_front());
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Async reset raised away from the clock edge, held across one rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_immediate", {xgmii_txc, xgmii_txd}, IDLE_W);
        chk("rst_rd_en", 72'(fifo_rd_en), 72'(0));
        @(posedge rd_clk);
        @(negedge rd_clk);
        rst = 1'b0;
        cyc++;
        model_reset();
    endtask

    function automatic int find_word(input logic [71:0] w);
        foreach (out_log[i]) if (out_log[i] === w) return i;
        return -1;
    endfunction

    // Checks frame_w appears contiguously on the output; returns index after it.
    task automatic chk_frame_out(input string name, output int after);
        int idx;
        idx = find_word(frame_w[0]);
        chk({name, "_found"}, 72'(idx >= 0), 72'(1));
        after = -1;
        if (idx >= 0) begin
            foreach (frame_w[k]) begin
                if (idx + k < out_log.size()) chk({name, "_word"}, out_log[idx+k], frame_w[k]);
                else chk({name, "_len"}, 72'(idx + k), 72'(out_log.size()));
            end
            after = idx + frame_w.size();
        end
    endtask

    initial begin
        logic [71:0] f1[$];
        int          after, gap;
        rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        rst = 1'b0;
        model_reset();

        // Empty FIFO: idle forever, no pops
        steps(10);
        chk("idle_txd_lit", 72'(xgmii_txd), 72'(64'h0707070707070707));
        chk("idle_txc_lit", 72'(xgmii_txc), 72'(8'hFF));
        chk("idle_frames_lit", 72'(frame_cnt), 72'(0));

        // 9-word frame, terminate in lane 3 (txc F8)
        do_reset(); out_log.delete();
        build_frame(9, 3);
        chk("term_txc_lit", 72'(frame_w[8][71:64]), 72'(8'hF8));
        foreach (frame_w[k]) fifo_q.push_back(frame_w[k]);
        steps(20);
        chk_frame_out("frame9", after);
        if (after >= 0) chk("frame9_idle_after", out_log[after], IDLE_W);
        chk("frame9_cnt_lit", 72'(frame_cnt), 72'(STATS ? 1 : 0));

        // Two frames back-to-back: gap of exactly TB_IPG idles
        do_reset(); out_log.delete();
        build_frame(5, -1); f1 = frame_w;
        foreach (f1[k]) fifo_q.push_back(f1[k]);
        build_frame(4, -1);
        foreach (frame_w[k]) fifo_q.push_back(frame_w[k]);
        steps(25);
        gap = -1;
        after = find_word(f1[4]);
        for (int i = after + 1; after >= 0 && i < out_log.size(); i++) begin
            if (out_log[i] !== IDLE_W) begin
                gap = i - after - 1;
                chk("b2b_next_start", out_log[i], frame_w[0]);
                break;
            end
        end
        chk("b2b_gap_lit", 72'(gap), 72'(3));
        chk("b2b_cnt_lit", 72'(frame_cnt), 72'(STATS ? 2 : 0));

        // Underrun: 4 of 8 words, rest withheld 20 cycles
        do_reset(); out_log.delete();
        build_frame(8, -1);
        for (int k = 0; k < 4; k++) fifo_q.push_back(frame_w[k]);
        steps(20);
        for (int k = 4; k < 8; k++) fifo_q.push_back(frame_w[k]);
        steps(15);
        after = find_word(frame_w[0]);
        chk("urun_found", 72'(after >= 0), 72'(1));
        if (after >= 0) begin
            for (int k = 0; k < 4; k++) chk("urun_word", out_log[after+k], frame_w[k]);
            chk("urun_err_lit", out_log[after+4], {8'hFF, 64'hFEFEFEFEFEFEFEFE});
            chk("urun_idle_after", out_log[after+5], IDLE_W);
        end
        chk("urun_drained", 72'(fifo_q.size()), 72'(0));
        chk("urun_cnt_lit", 72'(underrun_cnt), 72'(STATS ? 1 : 0));
        chk("urun_frames_lit", 72'(frame_cnt), 72'(0));

        // Two stray words ahead of a frame
        do_reset(); out_log.delete();
        fifo_q.push_back(rnd_word(8'h00));
        fifo_q.push_back(rnd_word(8'h00));
        build_frame(3, -1);
        foreach (frame_w[k]) fifo_q.push_back(frame_w[k]);
        steps(12);
        chk_frame_out("stray", after);
        chk("stray_drop_lit", 72'(drop_cnt), 72'(STATS ? 2 : 0));

        // Reset after word 3 of a 10-word frame
        do_reset(); out_log.delete();
        build_frame(10, 3);
        foreach (frame_w[k]) fifo_q.push_back(frame_w[k]);
        pops = 0;
        for (int i = 0; i < 50 && pops < 3; i++) step();
        chk("rmid_pops", 72'(pops), 72'(3));
        do_reset();
        steps(15);
        chk("rmid_drop_lit", 72'(drop_cnt), 72'(STATS ? 7 : 0));
        out_log.delete();
        build_frame(6, -1);
        foreach (frame_w[k]) fifo_q.push_back(frame_w[k]);
        steps(15);
        chk_frame_out("rmid_next", after);

        // Randomized traffic with write stalls, strays and enable toggling
        for (int ph = 0; ph < 3; ph++) begin
            wr_pct = (ph == 0) ? 100 : ((ph == 1) ? 80 : 50);
            for (int f = 0; f < 20; f++) begin
                if ($urandom_range(9, 0) < 2) pending.push_back(rnd_word(8'($urandom)));
                build_frame($urandom_range(12, 1), -1);
                foreach (frame_w[k]) pending.push_back(frame_w[k]);
            end
            begin
                int s;
                for (s = 0; s < 20000 && (pending.size() + fifo_q.size()) != 0; s++) begin
                    en_drv = ($urandom_range(9, 0) != 0);
                    step();
                end
                chk("rand_drain", 72'(pending.size() + fifo_q.size()), 72'(0));
            end
            en_drv = 1'b1;
            steps(20);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
